// File: rtl/async_fifo_rd_framer_if.sv
// -----------------------------------------------------------------------------
// async_fifo_rd_framer_if
//
// Bundles the two sides of the read-side framer:
//   FIFO side   : rempty (FIFO empty), rdata (read data), ren (read enable)
//   Stream side : m_valid, m_ready, m_data, m_last
//
// Handshake semantics (stream side): a word transfers on a rising clock edge
// where m_valid and m_ready are both high. Once m_valid is high it stays high,
// and m_data/m_last stay stable, until that transfer happens. m_valid never
// depends on m_ready. On the FIFO side a read is issued on every edge where
// ren is high. The matching rdata is valid for the whole following cycle.
//
// Modports:
//   master : the framer's view (drives ren and the m_* outputs)
//   slave  : the environment's view (drives rempty, rdata, m_ready)
// -----------------------------------------------------------------------------
interface async_fifo_rd_framer_if #(
  parameter int FIFO_WIDTH = 32
);
  logic                  rempty;
  logic [FIFO_WIDTH-1:0] rdata;
  logic                  ren;
  logic                  m_valid;
  logic                  m_ready;
  logic [FIFO_WIDTH-1:0] m_data;
  logic                  m_last;

  modport master (
    input  rempty,
    input  rdata,
    input  m_ready,
    output ren,
    output m_valid,
    output m_data,
    output m_last
  );

  modport slave (
    output rempty,
    output rdata,
    output m_ready,
    input  ren,
    input  m_valid,
    input  m_data,
    input  m_last
  );
endinterface

// File: rtl/async_fifo_rd_framer.sv
// -----------------------------------------------------------------------------
// async_fifo_rd_framer
//
// Read-side consumer for the asynchronous FIFO, living in the read clock
// domain. It issues FIFO reads, captures rdata one cycle later into a 3-entry
// circular skid buffer, and presents the buffered words as a valid/ready
// stream. m_last marks every PKT_LEN-th word. The read enable depends only on
// registers, enable and rempty, so there is no path from m_ready to ren.
//
// Ports:
//   rclk    : read-domain clock, rising edge
//   rst_n   : asynchronous active-low reset, released synchronously
//   enable  : when low no new reads are issued; buffered words still drain
//   bus     : FIFO side (rempty, rdata, ren) + stream side (m_valid, m_ready,
//             m_data, m_last)
//   pkt_cnt : completed packet count, wraps at 16 bits
// -----------------------------------------------------------------------------
module async_fifo_rd_framer #(
  parameter int FIFO_WIDTH = 32,
  parameter int PKT_LEN    = 16,
  parameter int BEAT_W     = 16
) (
  input  logic                           rclk,
  input  logic                           rst_n,
  input  logic                           enable,
  async_fifo_rd_framer_if.master         bus,
  output logic [15:0]                    pkt_cnt
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

  logic [FIFO_WIDTH-1:0] mem [3];
  logic [1:0]            head;
  logic [1:0]            tail;
  logic [1:0]            occ;
  logic                  pend;
  logic                  run;
  logic                  pop;
  logic [2:0]            fill;
  logic [BEAT_W-1:0]     beat;
  logic [FIFO_WIDTH-1:0] head_data;

  // Advance a pointer around the 3-entry ring.
  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Words already buffered plus the one still in flight from the FIFO. A new
  // read is only allowed when it is guaranteed a slot, even if nothing pops.
  assign fill = {1'b0, occ} + {2'b00, pend};

  // run holds reads off until the first edge after reset release, so ren is
  // low throughout reset and comes up synchronously.
  assign bus.ren = run & enable & ~bus.rempty & (fill < 3'd3);

  assign bus.m_valid = (occ != 2'd0);
  assign pop         = bus.m_valid & bus.m_ready;
  assign bus.m_last  = bus.m_valid & (beat == LAST_BEAT);

  always_comb begin
    head_data = mem[0];
    case (head)
      2'd1:    head_data = mem[1];
      2'd2:    head_data = mem[2];
      default: head_data = mem[0];
    endcase
  end

  assign bus.m_data = head_data;

  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      run     <= 1'b0;
      pend    <= 1'b0;
      head    <= 2'd0;
      tail    <= 2'd0;
      occ     <= 2'd0;
      beat    <= '0;
      pkt_cnt <= 16'd0;
      for (int i = 0; i < 3; i++) begin
        mem[i] <= '0;
      end
    end else begin
      run  <= 1'b1;
      pend <= bus.ren;

      // Capture the word requested on the previous edge.
      if (pend) begin
        for (int i = 0; i < 3; i++) begin
          if (tail == 2'(i)) begin
            mem[i] <= bus.rdata;
          end
        end
        tail <= next_ptr(tail);
      end

      occ <= occ + {1'b0, pend} - {1'b0, pop};

      if (pop) begin
        head <= next_ptr(head);
        if (beat == LAST_BEAT) begin
          beat    <= '0;
          pkt_cnt <= pkt_cnt + 16'd1;
        end else begin
          beat <= beat + BEAT_W'(1);
        end
      end
    end
  end

endmodule
